// File: rtl/flag_register_unit_if.sv
// Flag register unit port bundle: ALU writeback, direct flag write,
// save/restore requests, and the registered flag/stack status outputs.
interface flag_register_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  alu_valid;
    logic                  alu_set_flags;
    logic [1:0]            alu_kind;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  flag_wr_en;
    logic [3:0]            flag_wr_data;
    logic                  save_req;
    logic                  restore_req;
    logic                  negative_flag;
    logic                  zero_flag;
    logic                  carry_flag;
    logic                  overflow_flag;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  stack_err;

    modport master (
        output alu_valid, alu_set_flags, alu_kind, alu_a, alu_b, alu_result, alu_carry,
        output flag_wr_en, flag_wr_data, save_req, restore_req,
        input  negative_flag, zero_flag, carry_flag, overflow_flag,
        input  stack_full, stack_empty, stack_err
    );

    modport slave (
        input  alu_valid, alu_set_flags, alu_kind, alu_a, alu_b, alu_result, alu_carry,
        input  flag_wr_en, flag_wr_data, save_req, restore_req,
        output negative_flag, zero_flag, carry_flag, overflow_flag,
        output stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/flag_register_unit.sv
// Architectural N/Z/C/V flag register with ALU update, direct write and a
// small LIFO used to save/restore flags across interrupt entry/return.
module flag_register_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    flag_register_unit_if.slave   bus
);
    localparam int unsigned Msb    = DATA_WIDTH - 1;
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        KindAdd   = 2'd0,
        KindSub   = 2'd1,
        KindLogic = 2'd2,
        KindRsvd  = 2'd3
    } alu_kind_e;

    // Flags are packed {N, Z, C, V}
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        stack_q [STACK_DEPTH];
    logic [3:0]        stack_d [STACK_DEPTH];
    logic [DepthW-1:0] depth_q, depth_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              err_q, err_d;

    logic [3:0]        alu_flags;
    logic              is_full, is_empty;
    logic              push_ok, pop_ok;
    logic [IdxW-1:0]   push_idx, pop_idx;

    assign is_full  = (depth_q == DepthW'(STACK_DEPTH));
    assign is_empty = (depth_q == '0);
    assign push_idx = depth_q[IdxW-1:0];
    assign pop_idx  = IdxW'(depth_q - DepthW'(1));

    // Flags an ALU update would produce; LOGIC/reserved keep C and V
    always_comb begin
        alu_flags    = flags_q;
        alu_flags[3] = bus.alu_result[Msb];
        alu_flags[2] = (bus.alu_result == '0);
        unique case (alu_kind_e'(bus.alu_kind))
            KindAdd: begin
                alu_flags[1] = bus.alu_carry;
                alu_flags[0] = (bus.alu_a[Msb] == bus.alu_b[Msb]) &&
                               (bus.alu_result[Msb] != bus.alu_a[Msb]);
            end
            KindSub: begin
                alu_flags[1] = bus.alu_carry;
                alu_flags[0] = (bus.alu_a[Msb] != bus.alu_b[Msb]) &&
                               (bus.alu_result[Msb] != bus.alu_a[Msb]);
            end
            KindLogic, KindRsvd: begin
                alu_flags[1:0] = flags_q[1:0];
            end
            default: begin
                alu_flags[1:0] = flags_q[1:0];
            end
        endcase
    end

    // Stack control and flag source selection: restore > direct write > ALU
    always_comb begin
        flags_d = flags_q;
        stack_d = stack_q;
        depth_d = depth_q;

        // Simultaneous save+restore is an error and does neither
        push_ok = bus.save_req & ~bus.restore_req & ~is_full;
        pop_ok  = bus.restore_req & ~bus.save_req & ~is_empty;
        err_d   = (bus.save_req & bus.restore_req) |
                  (bus.save_req & ~bus.restore_req & is_full) |
                  (bus.restore_req & ~bus.save_req & is_empty);

        if (push_ok) begin
            // Push the pre-update flags; a same-cycle update still lands below
            stack_d[push_idx] = flags_q;
            depth_d           = depth_q + DepthW'(1);
        end

        if (pop_ok) begin
            flags_d = stack_q[pop_idx];
            depth_d = depth_q - DepthW'(1);
        end else if (bus.flag_wr_en) begin
            flags_d = bus.flag_wr_data;
        end else if (bus.alu_valid && bus.alu_set_flags) begin
            flags_d = alu_flags;
        end

        full_d  = (depth_d == DepthW'(STACK_DEPTH));
        empty_d = (depth_d == '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            stack_q <= '{default: '0};
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign bus.negative_flag = flags_q[3];
    assign bus.zero_flag     = flags_q[2];
    assign bus.carry_flag    = flags_q[1];
    assign bus.overflow_flag = flags_q[0];
    assign bus.stack_full    = full_q;
    assign bus.stack_empty   = empty_q;
    assign bus.stack_err     = err_q;
endmodule
